// File: rtl/cop_pkg.sv
// Shared constants and types for the SMIPS coprocessor stats unit.
package cop_pkg;

   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned DEF_IDX_W      = 5;
   localparam int unsigned DEF_STATS_IDX  = 10;
   localparam int unsigned DEF_CYC_IDX    = 12;
   localparam int unsigned DEF_INST_IDX   = 13;
   localparam int unsigned DEF_FINISH_IDX = 21;
   localparam int unsigned PASS_CODE      = 1;

   typedef struct packed {
      logic [DEF_IDX_W-1:0]  idx;
      logic [DEF_DATA_W-1:0] data;
   } cop_wr_req_t;

endpackage

// File: rtl/cop_stats_unit_if.sv
// mtc0 write / mfc0 read port bundle between the execute stage and the coprocessor.
interface cop_stats_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 5
) ();

   logic              write_en;
   logic [IDX_W-1:0]  write_idx;
   logic [DATA_W-1:0] write_data;
   logic              read_en;
   logic [IDX_W-1:0]  read_idx;
   logic [DATA_W-1:0] read_data;
   logic              read_valid;

   modport master (
      output write_en, write_idx, write_data, read_en, read_idx,
      input  read_data, read_valid
   );

   modport slave (
      input  write_en, write_idx, write_data, read_en, read_idx,
      output read_data, read_valid
   );

endinterface

// File: rtl/cop_counter.sv
// Enabled wrapping up-counter with asynchronous active-low reset.
module cop_counter #(
   parameter int unsigned W = 32
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)  count <= '0;
      else if (en) count <= count + W'(1);
   end

endmodule

// File: rtl/cop_stats_unit.sv
// Coprocessor register unit: stats enable, cycle/instret counters, sticky finish, registered mfc0 read.
// Optional macro COP_SIM_FINISH_EN adds a simulation-only pass/fail report and $finish.
module cop_stats_unit
   import cop_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned IDX_W      = DEF_IDX_W,
   parameter int unsigned STATS_IDX  = DEF_STATS_IDX,
   parameter int unsigned CYC_IDX    = DEF_CYC_IDX,
   parameter int unsigned INST_IDX   = DEF_INST_IDX,
   parameter int unsigned FINISH_IDX = DEF_FINISH_IDX
) (
   input  logic              CLK,
   input  logic              RST_N,
   cop_stats_unit_if.slave   bus,
   input  logic              inst_retire,
   output logic              stats_on,
   output logic              finish_valid,
   output logic [DATA_W-1:0] finish_code,
   output logic              passed
);

   localparam logic [IDX_W-1:0] STATS_I  = IDX_W'(STATS_IDX);
   localparam logic [IDX_W-1:0] CYC_I    = IDX_W'(CYC_IDX);
   localparam logic [IDX_W-1:0] INST_I   = IDX_W'(INST_IDX);
   localparam logic [IDX_W-1:0] FINISH_I = IDX_W'(FINISH_IDX);

   logic [DATA_W-1:0] cyc_count;
   logic [DATA_W-1:0] inst_count;
   logic [DATA_W-1:0] rd_mux;

   // Both counters see the pre-write stats_on, so an enable write only affects later cycles.
   cop_counter #(.W(DATA_W)) u_cyc (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (stats_on),
      .count (cyc_count)
   );

   cop_counter #(.W(DATA_W)) u_inst (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (stats_on && inst_retire),
      .count (inst_count)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stats_on     <= 1'b0;
         finish_valid <= 1'b0;
         finish_code  <= '0;
      end else if (bus.write_en) begin
         if (bus.write_idx == STATS_I)
            stats_on <= bus.write_data[0];
         if (bus.write_idx == FINISH_I && !finish_valid) begin
            finish_valid <= 1'b1;
            finish_code  <= bus.write_data;
         end
      end
   end

   assign passed = finish_valid && (finish_code == DATA_W'(PASS_CODE));

   always_comb begin
      rd_mux = '0;
      unique case (bus.read_idx)
         STATS_I:  rd_mux = {{(DATA_W-1){1'b0}}, stats_on};
         CYC_I:    rd_mux = cyc_count;
         INST_I:   rd_mux = inst_count;
         FINISH_I: rd_mux = finish_code;
         default:  rd_mux = '0;
      endcase
   end

   // Read samples pre-update state, so a same-cycle write to the same index returns the old value.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.read_valid <= 1'b0;
         bus.read_data  <= '0;
      end else begin
         bus.read_valid <= bus.read_en;
         if (bus.read_en)
            bus.read_data <= rd_mux;
      end
   end

`ifdef COP_SIM_FINISH_EN
   logic sim_reported;

   always @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sim_reported <= 1'b0;
      end else if (finish_valid && !sim_reported) begin
         sim_reported <= 1'b1;
         if (passed) $display("Passed");
         else        $display("Failed");
         case (finish_code[1:0])
            2'd0:    $finish(0);
            2'd1:    $finish(1);
            default: $finish(2);
         endcase
      end
   end
`endif

endmodule
